// File: rtl/apb_uart_tx_fifo.sv
// Purpose: byte FIFO between the APB TX data register and the UART transmitter, with fill status, sticky overflow and a low-watermark interrupt.
// Latency: first-word-fall-through; a byte pushed at edge N is presented on tx_data_o/tx_valid_o right after edge N. irq_o lags count by one cycle.
// Backpressure: push_ready_o drops when full and does not depend on tx_ready_i; a push while full is dropped and sets overflow_o.
module apb_uart_tx_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   localparam int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr_i,
   input  logic                  push_valid_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   output logic                  push_ready_o,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic [CNT_W-1:0]      count_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  overflow_o,
   input  logic                  cfg_irq_en_i,
   input  logic [CNT_W-1:0]      cfg_thresh_i,
   output logic                  irq_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  irq;
   logic                  push_fire;
   logic                  pop_fire;

   // Flags come only from the registered count, so ready never sees tx_ready_i.
   assign empty_o      = (count == '0);
   assign full_o       = (count == CNT_W'(DEPTH));
   assign push_ready_o = ~full_o;
   assign tx_valid_o   = ~empty_o;
   assign tx_data_o    = mem[rd_ptr];
   assign count_o      = count;
   assign overflow_o   = overflow;
   assign irq_o        = irq;

   assign push_fire = push_valid_i && push_ready_o;
   assign pop_fire  = tx_valid_o && tx_ready_i;

   // Pointer, count and overflow state; a clear wins over any concurrent push or pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_fire && !pop_fire) begin
            count <= count + CNT_W'(1);
         end else if (pop_fire && !push_fire) begin
            count <= count - CNT_W'(1);
         end
         if (push_valid_i && full_o) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage is not reset; a write only lands when the push is actually accepted.
   always_ff @(posedge clk) begin
      if (!reset && !clr_i && push_fire) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

   // Low-watermark level interrupt, registered from the pre-edge count.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= cfg_irq_en_i && (count <= cfg_thresh_i);
      end
   end

endmodule
